// File: rtl/status_bank.sv
// Banked NZCV-style status flags with masked writes and a shared save/restore stack.
// All state updates on the falling clock edge; reset is asynchronous.
module status_bank #(
   parameter int WIDTH       = 4,
   parameter int NUM_BANKS   = 2,
   parameter int STACK_DEPTH = 4,
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BW-1:0]    bank_sel,
   input  logic             s,
   input  logic [WIDTH-1:0] status_bits_in,
   input  logic [WIDTH-1:0] wr_mask,
   input  logic             push,
   input  logic             pop,
   input  logic             clr_err,
   output logic [WIDTH-1:0] status_bits_out,
   output logic [DW-1:0]    depth,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);
   localparam logic [BW:0]   BANK_LIMIT = (BW + 1)'(NUM_BANKS);

   logic [WIDTH-1:0] banks [NUM_BANKS];
   logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [DW-1:0]    depth_reg;
   logic             err_reg;

   logic             bank_ok;
   logic [WIDTH-1:0] cur_flags;
   logic [WIDTH-1:0] top_flags;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    top_idx;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;
   logic             wr_ok;
   logic             err_event;
   logic [NUM_BANKS-1:0] hit;

   assign bank_ok   = {1'b0, bank_sel} < BANK_LIMIT;
   assign cur_flags = bank_ok ? banks[bank_sel] : '0;
   assign full      = (depth_reg == FULL_DEPTH);
   assign empty     = (depth_reg == '0);
   assign push_idx  = AW'(depth_reg);
   assign top_idx   = AW'(depth_reg - 1'b1);
   assign top_flags = stack_mem[top_idx];

   // A bad bank blocks every operation; a collision blocks both stack ops.
   assign do_push   = push && !pop && !full && bank_ok;
   assign do_pop    = pop && !push && !empty && bank_ok;
   assign wr_ok     = s && bank_ok && !do_pop;
   assign err_event = (push && pop)
                    || (push && !pop && full)
                    || (pop && !push && empty)
                    || ((s || push || pop) && !bank_ok);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_hit
         assign hit[gi] = (bank_sel == BW'(gi));
      end
   endgenerate

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BANKS; i++) banks[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (do_pop && hit[i])
               banks[i] <= top_flags;
            else if (wr_ok && hit[i])
               banks[i] <= (banks[i] & ~wr_mask) | (status_bits_in & wr_mask);
         end
      end
   end

   // Stack slots need no reset: depth alone decides which entries are live.
   always_ff @(negedge clk) begin
      if (do_push) stack_mem[push_idx] <= cur_flags;
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         depth_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         if (do_push)
            depth_reg <= depth_reg + 1'b1;
         else if (do_pop)
            depth_reg <= depth_reg - 1'b1;
         if (err_event)
            err_reg <= 1'b1;
         else if (clr_err)
            err_reg <= 1'b0;
      end
   end

   assign status_bits_out = cur_flags;
   assign depth           = depth_reg;
   assign stack_full      = full;
   assign stack_empty     = empty;
   assign stack_err       = err_reg;

endmodule

// File: tb/tb_status_bank.sv
// Scoreboard bench for status_bank (3 banks, so bank_sel=3 is out of range).
// The driver queues hand-computed expectations; a monitor pops and compares them.
module tb_status_bank;

   logic       clk;
   logic       rst;
   logic [1:0] bank_sel;
   logic       s;
   logic [3:0] status_bits_in;
   logic [3:0] wr_mask;
   logic       push;
   logic       pop;
   logic       clr_err;
   logic [3:0] status_bits_out;
   logic [2:0] depth;
   logic       stack_full;
   logic       stack_empty;
   logic       stack_err;

   status_bank #(.WIDTH(4), .NUM_BANKS(3), .STACK_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bank_sel(bank_sel), .s(s),
      .status_bits_in(status_bits_in), .wr_mask(wr_mask),
      .push(push), .pop(pop), .clr_err(clr_err),
      .status_bits_out(status_bits_out), .depth(depth),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   string      q_name [$];
   logic [3:0] q_out [$];
   logic [2:0] q_depth [$];
   logic       q_err [$];
   event       sample_ev;

   // Monitor: compares live DUT outputs against the oldest queued expectation.
   initial begin
      string      n;
      logic [3:0] eo;
      logic [2:0] ed;
      logic       ee;
      forever begin
         @(sample_ev);
         n  = q_name.pop_front();
         eo = q_out.pop_front();
         ed = q_depth.pop_front();
         ee = q_err.pop_front();
         checks += 5;
         if (status_bits_out !== eo) begin
            errors++;
            $display("FAIL %s out: got %b expected %b", n, status_bits_out, eo);
         end
         if (depth !== ed) begin
            errors++;
            $display("FAIL %s depth: got %0d expected %0d", n, depth, ed);
         end
         if (stack_full !== (ed == 3'd4)) begin
            errors++;
            $display("FAIL %s full: got %b expected %b", n, stack_full, ed == 3'd4);
         end
         if (stack_empty !== (ed == 3'd0)) begin
            errors++;
            $display("FAIL %s empty: got %b expected %b", n, stack_empty, ed == 3'd0);
         end
         if (stack_err !== ee) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", n, stack_err, ee);
         end
         $display("check %-14s out=%b depth=%0d full=%b empty=%b err=%b",
                  n, status_bits_out, depth, stack_full, stack_empty, stack_err);
      end
   end

   // One operation: drive after the rising edge, sampled at the falling edge.
   task automatic op(input logic [1:0] sel, input logic ws, input logic [3:0] din,
                     input logic [3:0] msk, input logic pu, input logic po,
                     input logic cl);
      @(posedge clk);
      bank_sel = sel; s = ws; status_bits_in = din; wr_mask = msk;
      push = pu; pop = po; clr_err = cl;
      @(negedge clk);
      #1;
      s = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
      status_bits_in = 4'b0; wr_mask = 4'b0;
   endtask

   task automatic chk(input logic [1:0] sel, input logic [3:0] eo,
                      input logic [2:0] ed, input logic ee, input string n);
      bank_sel = sel;
      #1;
      q_name.push_back(n);
      q_out.push_back(eo);
      q_depth.push_back(ed);
      q_err.push_back(ee);
      ->sample_ev;
      #1;
   endtask

   initial begin
      rst = 1'b1; bank_sel = 2'd0; s = 1'b0; status_bits_in = 4'b0;
      wr_mask = 4'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk(2'd0, 4'b0000, 3'd0, 1'b0, "reset");
      rst = 1'b0;

      // masked writes
      op(2'd0, 1, 4'b1010, 4'b1111, 0, 0, 0);
      chk(2'd0, 4'b1010, 3'd0, 1'b0, "write_full");
      op(2'd0, 1, 4'b0101, 4'b0011, 0, 0, 0);
      chk(2'd0, 4'b1001, 3'd0, 1'b0, "write_masked");
      op(2'd0, 1, 4'b1111, 4'b0000, 0, 0, 0);
      chk(2'd0, 4'b1001, 3'd0, 1'b0, "mask_zero");
      chk(2'd1, 4'b0000, 3'd0, 1'b0, "bank1_clean");

      // stack round-trip with same-edge writes
      op(2'd0, 1, 4'b1100, 4'b1111, 0, 0, 0);
      op(2'd0, 1, 4'b0011, 4'b1111, 1, 0, 0);
      chk(2'd0, 4'b0011, 3'd1, 1'b0, "push_with_s");
      op(2'd0, 1, 4'b1111, 4'b1111, 0, 1, 0);
      chk(2'd0, 4'b1100, 3'd0, 1'b0, "pop_beats_s");

      // overflow / underflow
      for (int i = 1; i <= 4; i++) op(2'd0, 0, 4'b0, 4'b0, 1, 0, 0);
      chk(2'd0, 4'b1100, 3'd4, 1'b0, "four_pushes");
      op(2'd0, 0, 4'b0, 4'b0, 1, 0, 0);
      chk(2'd0, 4'b1100, 3'd4, 1'b1, "overflow");
      op(2'd0, 0, 4'b0, 4'b0, 0, 0, 1);
      chk(2'd0, 4'b1100, 3'd4, 1'b0, "clr_err");
      for (int i = 1; i <= 4; i++) op(2'd0, 0, 4'b0, 4'b0, 0, 1, 0);
      chk(2'd0, 4'b1100, 3'd0, 1'b0, "four_pops");
      // failed pop leaves the write alone; error set beats clr_err
      op(2'd0, 1, 4'b0001, 4'b1111, 0, 1, 1);
      chk(2'd0, 4'b0001, 3'd0, 1'b1, "underflow");
      op(2'd0, 0, 4'b0, 4'b0, 0, 0, 1);

      // collision and bad bank
      op(2'd0, 0, 4'b0, 4'b0, 1, 0, 0);
      op(2'd0, 0, 4'b0, 4'b0, 1, 1, 0);
      chk(2'd0, 4'b0001, 3'd1, 1'b1, "collision");
      op(2'd0, 0, 4'b0, 4'b0, 0, 0, 1);
      op(2'd2, 1, 4'b0011, 4'b1111, 0, 0, 0);
      op(2'd3, 1, 4'b1111, 4'b1111, 0, 0, 0);
      chk(2'd3, 4'b0000, 3'd1, 1'b1, "bad_bank_s");
      chk(2'd0, 4'b0001, 3'd1, 1'b1, "bad_b0");
      chk(2'd1, 4'b0000, 3'd1, 1'b1, "bad_b1");
      chk(2'd2, 4'b0011, 3'd1, 1'b1, "bad_b2");
      op(2'd0, 0, 4'b0, 4'b0, 0, 0, 1);
      op(2'd3, 0, 4'b0, 4'b0, 1, 0, 0);
      chk(2'd3, 4'b0000, 3'd1, 1'b1, "bad_bank_push");
      op(2'd0, 0, 4'b0, 4'b0, 0, 0, 1);

      // async reset mid-operation
      op(2'd0, 0, 4'b0, 4'b0, 1, 0, 0);
      op(2'd1, 1, 4'b0110, 4'b1111, 0, 0, 0);
      chk(2'd1, 4'b0110, 3'd2, 1'b0, "pre_reset");
      @(posedge clk);
      #2 rst = 1'b1;
      chk(2'd1, 4'b0000, 3'd0, 1'b0, "async_reset");
      rst = 1'b0;
      op(2'd1, 0, 4'b0, 4'b0, 0, 1, 0);
      chk(2'd1, 4'b0000, 3'd0, 1'b1, "pop_after_rst");

      for (int i = 0; i < 100 && q_name.size() != 0; i++) @(posedge clk);
      if (q_name.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q_name.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
